// File: rtl/filter_pkg.sv
// filter_pkg: sizing constants, FSM state and sample types shared by the moving-average filter
package filter_pkg;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 24;

    typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;
    typedef logic signed [DATA_W-1:0] sample_t;

    // Pre-divide by DEPTH so the window sum is already the average
    function automatic sample_t scale(input sample_t s);
        return s >>> ADDR_W;
    endfunction
endpackage

// File: rtl/filter_datapath.sv
// filter_datapath: DEPTH-entry sample window RAM with asynchronous read of the oldest entry
module filter_datapath
    import filter_pkg::*;
(
    input  logic                     clk,
    input  logic                     write,
    input  logic signed [DATA_W-1:0] writedata,
    input  logic [ADDR_W-1:0]        write_addr,
    input  logic                     read,
    input  logic [ADDR_W-1:0]        read_addr,
    input  logic                     full,
    output logic signed [DATA_W-1:0] buffer_out
);
    sample_t mem_q [DEPTH];

    always_ff @(posedge clk)
        if (write) mem_q[write_addr] <= writedata;

    // Unwritten slots are never exposed while the window is still filling
    assign buffer_out = (full || read) ? mem_q[read_addr] : '0;
endmodule

// File: rtl/filter_avg_ctrl.sv
// filter_avg_ctrl: 8-tap moving-average controller (FSM, pointer, accumulator, outputs).
// FILTER_PREFILL_AVG_EN: also emit averages while the window is still filling.
module filter_avg_ctrl
    import filter_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     sample_valid,
    input  logic signed [DATA_W-1:0] sample_in,
    output logic                     ready,
    output logic                     avg_valid,
    output logic signed [DATA_W-1:0] avg_out,
    output logic [ADDR_W:0]          fill_level
);
    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_LVL = (ADDR_W+1)'(DEPTH-1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   fill_q, fill_d;
    sample_t           acc_q, acc_d, avg_q, avg_d, scaled, buffer_out;
    logic              valid_q, valid_d, accept, dp_read, full, clear;

    assign ready      = state_q != FLUSH;
    assign full       = state_q == RUN;
    assign accept     = sample_valid && ready && !flush;
    assign dp_read    = accept && full;
    assign clear      = flush || state_q == FLUSH;
    assign scaled     = scale(sample_in);
    assign avg_valid  = valid_q;
    assign avg_out    = avg_q;
    assign fill_level = fill_q;

    filter_datapath u_dp (
        .clk        (clk),
        .write      (accept),
        .writedata  (scaled),
        .write_addr (wr_ptr_q),
        .read       (dp_read),
        .read_addr  (wr_ptr_q),
        .full       (full),
        .buffer_out (buffer_out)
    );

    always_comb begin
        state_d = state_q;
        if (flush) state_d = FLUSH;
        else if (state_q == FLUSH) state_d = FILL;
        else if (accept && fill_q == LAST_LVL) state_d = RUN;
        acc_d    = clear ? '0 : accept ? acc_q + scaled - (dp_read ? buffer_out : '0) : acc_q;
        wr_ptr_d = clear ? '0 : accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
        fill_d   = clear ? '0 : (accept && fill_q != FULL_LVL) ? fill_q + 1'b1 : fill_q;
`ifdef FILTER_PREFILL_AVG_EN
        valid_d  = accept;
`else
        valid_d  = accept && state_d == RUN;
`endif
        avg_d    = valid_d ? acc_d : avg_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= FILL;
            wr_ptr_q <= '0;
            fill_q   <= '0;
            acc_q    <= '0;
            avg_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
            acc_q    <= acc_d;
            avg_q    <= avg_d;
            valid_q  <= valid_d;
        end
    end
endmodule
